// File: rtl/cpu_core_param_if.sv
// Interface for cpu_core_param: program memory in, architectural state out.
// CPU_SINGLE_STEP_EN adds the step input to both modports.
interface cpu_core_param_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int RAM_SIZE = 8
);
  logic [RAM_SIZE*32-1:0]      ram;
  logic [NUM_REGS*DATA_W-1:0]  regs;
  logic [7:0]                  flags;
  logic [31:0]                 ir;
  logic [7:0]                  pc;
  logic [1:0]                  state;
  logic [15:0]                 clks;
  logic                        halted;
`ifdef CPU_SINGLE_STEP_EN
  logic                        step;

  modport master (input ram, input step,
                  output regs, output flags, output ir, output pc,
                  output state, output clks, output halted);
  modport slave  (output ram, output step,
                  input regs, input flags, input ir, input pc,
                  input state, input clks, input halted);
`else
  modport master (input ram,
                  output regs, output flags, output ir, output pc,
                  output state, output clks, output halted);
  modport slave  (output ram,
                  input regs, input flags, input ir, input pc,
                  input state, input clks, input halted);
`endif
endinterface

// File: rtl/cpu_core_param.sv
// Parametrised 3-cycle (FETCH/DECODE/EXECUTE) CPU with flags, jumps, HLT and PC fault.
// Optional macro CPU_SINGLE_STEP_EN gates FETCH on the step input.
module cpu_core_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int RAM_SIZE = 8
) (
  input  logic             clk,
  input  logic             reset,
  cpu_core_param_if.master bus
);
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam logic [7:0] OP_HLT  = 8'h01;
  localparam logic [7:0] OP_JMPI = 8'h02;
  localparam logic [7:0] OP_JMPR = 8'h03;
  localparam logic [7:0] OP_MOVI = 8'h04;
  localparam logic [7:0] OP_MOVR = 8'h05;
  localparam logic [7:0] OP_ADD  = 8'h06;
  localparam logic [7:0] OP_SUB  = 8'h07;
  localparam logic [7:0] OP_CMP  = 8'h08;
  localparam logic [7:0] OP_JZ   = 8'h09;
  localparam logic [7:0] OP_JC   = 8'h0A;

  state_t              r_state, w_state_next;
  logic [7:0]          r_pc, w_pc_next;
  logic [7:0]          r_flags, w_flags_next;
  logic [31:0]         r_ir, w_ir_next, w_fetch;
  logic [15:0]         r_clks, w_clks_next;
  logic                r_halted;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic [7:0]          w_op, w_a, w_b, w_jmp_reg;
  logic [DATA_W-1:0]   w_rd_a, w_rd_b, w_imm, w_wr_data;
  logic [DATA_W:0]     w_add, w_sub;
  logic [7:0]          w_add_flags, w_sub_flags;
  logic                w_wr_en, w_pc_oob, w_go;

  assign w_op      = r_ir[23:16];
  assign w_a       = r_ir[15:8];
  assign w_b       = r_ir[7:0];
  assign w_imm     = DATA_W'(w_b);
  assign w_jmp_reg = 8'(w_rd_b);
  assign w_pc_oob  = (9'(r_pc) >= 9'(RAM_SIZE));

`ifdef CPU_SINGLE_STEP_EN
  assign w_go = bus.step;
`else
  assign w_go = 1'b1;
`endif

  // Out-of-range indices fall through the loops and read as zero.
  always_comb begin
    w_rd_a  = '0;
    w_rd_b  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_a == 8'(i)) w_rd_a = r_regs[i];
      if (w_b == 8'(i)) w_rd_b = r_regs[i];
    end
  end

  always_comb begin
    w_fetch = '0;
    for (int i = 0; i < RAM_SIZE; i++) begin
      if (r_pc == 8'(i)) w_fetch = bus.ram[32*i +: 32];
    end
  end

  assign w_add = {1'b0, w_rd_a} + {1'b0, w_rd_b};
  assign w_sub = {1'b0, w_rd_a} - {1'b0, w_rd_b};
  assign w_add_flags = {r_flags[7], 4'b0000, w_add[DATA_W-1], w_add[DATA_W], ~|w_add[DATA_W-1:0]};
  assign w_sub_flags = {r_flags[7], 4'b0000, w_sub[DATA_W-1], w_sub[DATA_W], ~|w_sub[DATA_W-1:0]};

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_flags_next = r_flags;
    w_wr_en      = 1'b0;
    w_wr_data    = w_rd_a;
    w_clks_next  = (r_state != ST_HALT && r_clks != 16'hFFFF) ? r_clks + 16'd1 : r_clks;
    unique case (r_state)
      ST_FETCH: begin
        if (!w_go) begin
          w_clks_next = r_clks;
        end else if (w_pc_oob) begin
          w_flags_next[7] = 1'b1;
          w_state_next    = ST_HALT;
        end else begin
          w_ir_next    = w_fetch;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_pc_next    = r_pc + 8'd1;
        w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_next = ST_FETCH;
        case (w_op)
          OP_HLT:  w_state_next = ST_HALT;
          OP_JMPI: w_pc_next = w_b;
          OP_JMPR: w_pc_next = w_jmp_reg;
          OP_MOVI: begin w_wr_en = 1'b1; w_wr_data = w_imm;  end
          OP_MOVR: begin w_wr_en = 1'b1; w_wr_data = w_rd_b; end
          OP_ADD: begin
            w_wr_en      = 1'b1;
            w_wr_data    = w_add[DATA_W-1:0];
            w_flags_next = w_add_flags;
          end
          OP_SUB: begin
            w_wr_en      = 1'b1;
            w_wr_data    = w_sub[DATA_W-1:0];
            w_flags_next = w_sub_flags;
          end
          OP_CMP:  w_flags_next = w_sub_flags;
          OP_JZ:   if (r_flags[0]) w_pc_next = w_b;
          OP_JC:   if (r_flags[1]) w_pc_next = w_b;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_flags  <= '0;
      r_clks   <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_ir     <= w_ir_next;
      r_flags  <= w_flags_next;
      r_clks   <= w_clks_next;
      r_halted <= (w_state_next == ST_HALT);
    end
  end

  // Writes to an index >= NUM_REGS match no entry and are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_en && w_a == 8'(i)) r_regs[i] <= w_wr_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign bus.regs[gi*DATA_W +: DATA_W] = r_regs[gi];
    end
  endgenerate

  assign bus.flags  = r_flags;
  assign bus.ir     = r_ir;
  assign bus.pc     = r_pc;
  assign bus.state  = r_state;
  assign bus.clks   = r_clks;
  assign bus.halted = r_halted;
endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: program table with a scoreboard queue, plus
// hand-written async-reset and wide-configuration sequences.
module tb_cpu_core_param;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic reset_w = 1'b0;
  always #5 clk = ~clk;

  cpu_core_param_if #(.DATA_W(8),  .NUM_REGS(4), .RAM_SIZE(8)) bus ();
  cpu_core_param_if #(.DATA_W(12), .NUM_REGS(8), .RAM_SIZE(8)) bus_w ();

  cpu_core_param #(.DATA_W(8), .NUM_REGS(4), .RAM_SIZE(8)) dut (
    .clk(clk), .reset(reset_n), .bus(bus));
  cpu_core_param #(.DATA_W(12), .NUM_REGS(8), .RAM_SIZE(8)) dut_w (
    .clk(clk), .reset(reset_w), .bus(bus_w));

`ifdef CPU_SINGLE_STEP_EN
  initial begin
    bus.step   = 1'b1;
    bus_w.step = 1'b1;
  end
`endif

  typedef struct {
    string       name;
    logic [255:0] prog;
    int          ncyc;
    logic [31:0] regs;
    logic [7:0]  flags;
    logic [7:0]  pc;
    logic [1:0]  state;
    logic [15:0] clks;
    logic [31:0] ir;
  } vec_t;

  vec_t vecs[7];
  vec_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [255:0] mk(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  function automatic vec_t v(input string n, input logic [255:0] p, input int c,
                             input logic [31:0] r, input logic [7:0] f, input logic [7:0] pc,
                             input logic [1:0] st, input logic [15:0] ck, input logic [31:0] ir);
    vec_t t;
    t.name = n; t.prog = p; t.ncyc = c; t.regs = r; t.flags = f;
    t.pc = pc; t.state = st; t.clks = ck; t.ir = ir;
    return t;
  endfunction

  task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".rst_regs"},   64'(bus.regs),   64'h0);
    check({tag, ".rst_pc"},     64'(bus.pc),     64'h0);
    check({tag, ".rst_state"},  64'(bus.state),  64'h0);
    check({tag, ".rst_clks"},   64'(bus.clks),   64'h0);
    check({tag, ".rst_halted"}, 64'(bus.halted), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t e;
    vecs[0] = v("loop_mov", mk(32'h000400AA, 32'h000401BB, 32'h00050200, 32'h00050301,
                               32'h00040002, 32'h000401DD, 32'h00030000, 32'h0),
                21, 32'hBBAADD02, 8'h00, 8'h02, 2'd0, 16'd21, 32'h00030000);
    vecs[1] = v("add_carry", mk(32'h000400F0, 32'h00040120, 32'h00060001, 32'h00010000,
                                32'h0, 32'h0, 32'h0, 32'h0),
                62, 32'h00002010, 8'h02, 8'h04, 2'd3, 16'd12, 32'h00010000);
    vecs[2] = v("sub_jz", mk(32'h00040005, 32'h00040105, 32'h00070001, 32'h00090006,
                             32'h00040077, 32'h00010000, 32'h00010000, 32'h0),
                30, 32'h00000500, 8'h01, 8'h07, 2'd3, 16'd15, 32'h00010000);
    vecs[3] = v("pc_fault", mk(32'h00020010, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0),
                10, 32'h00000000, 8'h80, 8'h10, 2'd3, 16'd4, 32'h00020010);
    vecs[4] = v("cmp_jc", mk(32'h00040003, 32'h00040105, 32'h00080001, 32'h000A0005,
                             32'h00040077, 32'h00010000, 32'h0, 32'h0),
                30, 32'h00000503, 8'h06, 8'h06, 2'd3, 16'd15, 32'h00010000);
    vecs[5] = v("oob_reg", mk(32'h00040005, 32'h00040912, 32'h00050009, 32'h00040101,
                              32'h00070901, 32'h00FF0000, 32'h00010000, 32'h0),
                30, 32'h00000100, 8'h06, 8'h07, 2'd3, 16'd21, 32'h00010000);
    vecs[6] = v("self_jmp", mk(32'h00020000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0),
                30, 32'h00000000, 8'h00, 8'h00, 2'd0, 16'd30, 32'h00020000);

    bus.ram   = '0;
    bus_w.ram = '0;

    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      reset_n = 1'b0;
      bus.ram = vecs[k].prog;
      #1;
      if (k == 0) check_reset_state("init");
      sb_q.push_back(vecs[k]);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (vecs[k].ncyc) @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check({e.name, ".regs"},   64'(bus.regs),   64'(e.regs));
      check({e.name, ".flags"},  64'(bus.flags),  64'(e.flags));
      check({e.name, ".pc"},     64'(bus.pc),     64'(e.pc));
      check({e.name, ".state"},  64'(bus.state),  64'(e.state));
      check({e.name, ".clks"},   64'(bus.clks),   64'(e.clks));
      check({e.name, ".ir"},     64'(bus.ir),     64'(e.ir));
      check({e.name, ".halted"}, 64'(bus.halted), 64'(e.state == 2'd3));
      $display("vec %0d %s: regs=%h flags=%h pc=%h state=%0d clks=%0d",
               k, e.name, bus.regs, bus.flags, bus.pc, bus.state, bus.clks);
    end

    // Async reset landing between clock edges while MOV r0,AA is in EXECUTE.
    @(negedge clk);
    reset_n = 1'b0;
    bus.ram = mk(32'h000400AA, 32'h00010000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst.pre_state", 64'(bus.state), 64'd2);
    check("midrst.pre_pc",    64'(bus.pc),    64'd1);
    #1 reset_n = 1'b0;
    #1 check_reset_state("midrst");
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst.r0",    64'(bus.regs[7:0]), 64'hAA);
    check("midrst.state", 64'(bus.state),     64'd3);
    check("midrst.clks",  64'(bus.clks),      64'd6);
    $display("midrst: regs=%h state=%0d clks=%0d", bus.regs, bus.state, bus.clks);

    // Wide configuration: 12-bit data, 8 registers.
    @(negedge clk);
    reset_w   = 1'b0;
    bus_w.ram = mk(32'h000407FF, 32'h000400FF, 32'h00040701, 32'h00060007,
                   32'h00010000, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset_w = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("wide.r0",    64'(bus_w.regs[11:0]),  64'h100);
    check("wide.r7",    64'(bus_w.regs[95:84]), 64'h001);
    check("wide.flags", 64'(bus_w.flags),       64'h00);
    check("wide.state", 64'(bus_w.state),       64'd3);
    check("wide.pc",    64'(bus_w.pc),          64'h05);
    check("wide.clks",  64'(bus_w.clks),        64'd15);
    $display("wide: r0=%h r7=%h flags=%h clks=%0d",
             bus_w.regs[11:0], bus_w.regs[95:84], bus_w.flags, bus_w.clks);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
